sys_reg_file: RTL and testbench
===============================

SYS_REG_FILE -- requirements
Module: sys_reg_file

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset, named as in the codebase: iCLOCK in, inRESET in.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- iCLOCK  in  1  core clock.
- inRESET  in  1  async active-low reset.
- iWR_VALID  in  1  register write request from execute.
- oWR_BUSY  out  1  write not accepted this cycle; source holds request.
- iWR_ADDR  in  2  write target: 0=SR1, 1=PSR, 2=PPC, 3=reserved.
- iWR_DATA  in  32  write value.
- iRD_ADDR  in  2  read select, same encoding.
- oRD_DATA  out  32  read value, combinational from current registers.
- iEXC_VALID  in  1  exception/interrupt entry request, level-held until done.
- iEXC_PC  in  32  PC to save on entry.
- iRET_VALID  in  1  return-from-exception request, level-held until done.
- oEXC_DONE  out  1  one-cycle pulse, entry complete.
- oRET_DONE  out  1  one-cycle pulse, return complete.
- oSR1  out  32  full SR1 (masked).
- oSR1_MMUMOD  out  2  SR1[1:0].
- oSR1_IM  out  1  SR1[2].
- oSR1_CMOD  out  2  SR1[6:5].

Function
REQ-003 SHALL hold three 32-bit registers: SR1, PSR (saved SR1) and PPC (saved PC).
REQ-004 SR1 writable mask SHALL be bits [6:5], [2] and [1:0]. All other SR1 bits SHALL always read 0. PSR SHALL use the same mask. PPC SHALL be fully writable.
REQ-005 FSM states SHALL be IDLE, EXC_SAVE, EXC_SET and RET.
REQ-006 In IDLE with iEXC_VALID=1:
- next state EXC_SAVE.
- at that edge, PSR<=SR1 and PPC<=iEXC_PC.
REQ-007 EXC_SAVE -> EXC_SET: SR1.IM<=0 and SR1.CMOD<=2'b00 (kernel). MMUMOD SHALL be unchanged.
REQ-008 EXC_SET SHALL assert oEXC_DONE for exactly one cycle, then return to IDLE. Entry latency SHALL be 3 cycles from acceptance to done pulse.
REQ-009 In IDLE with iRET_VALID=1 and iEXC_VALID=0:
- next state RET.
- at that edge, SR1<=PSR.
REQ-010 RET SHALL assert oRET_DONE for one cycle, then return to IDLE.
REQ-011 Write acceptance: in IDLE with iWR_VALID=1 and neither iEXC_VALID nor iRET_VALID asserted, the addressed register SHALL be updated at that edge with the mask applied. A write to address 3 SHALL be accepted and discarded.
REQ-012 oWR_BUSY SHALL be 1 when state!=IDLE, or when iEXC_VALID or iRET_VALID is 1 in IDLE. Otherwise it SHALL be 0. It SHALL be combinational.
REQ-013 Priority SHALL be exception > return > write. A losing request SHALL be neither lost nor partially applied.
REQ-014 A request asserted while a sequence is in progress SHALL be sampled only on return to IDLE. No back-to-back overlap is allowed.
REQ-015 oRD_DATA SHALL return masked SR1, PSR, PPC, or 0 for address 3. A read in the same cycle as a write SHALL return the pre-write value.
REQ-016 oSR1_* outputs SHALL reflect SR1 with no added latency.

Reset
REQ-017 On inRESET=0, asynchronously:
- SR1, PSR and PPC SHALL be 0 (CMOD=kernel, IM=0, MMUMOD=0).
- state SHALL be IDLE.
- oEXC_DONE and oRET_DONE SHALL be 0.
- oWR_BUSY SHALL follow REQ-012.
REQ-018 Reset mid-sequence SHALL abort the sequence with no done pulse. Registers SHALL take reset values, not partially saved ones.

Structure
REQ-019 SHALL place the register address encodings, SR1 field positions, writable mask, CMOD kernel value and FSM state encodings in the shared core.h define set.
REQ-020 SHALL be one module with no sub-module. The mask/merge logic SHALL be a local function.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset -> oSR1=0x00000000, oWR_BUSY=0, no done pulses; write SR1=0xFFFFFFFF -> oSR1=0x00000067, MMUMOD=3, IM=1, CMOD=3.
- SR1=0x67, iEXC_VALID with iEXC_PC=0x00001000 -> PSR=0x67, PPC=0x1000, then oSR1=0x03, oEXC_DONE pulse on cycle 3, oWR_BUSY=1 throughout.
- After the entry above, iRET_VALID -> oSR1=0x67 next cycle, oRET_DONE single pulse.
- iEXC_VALID, iRET_VALID and iWR_VALID(SR1, 0x04) in the same cycle -> entry runs first, return next, write last; final oSR1=0x04.
- Write to addr 3 with 0xDEADBEEF -> accepted, read addr 3 = 0; same-cycle read of SR1 during write returns old value.
- inRESET low during EXC_SET -> SR1, PSR, PPC = 0, no oEXC_DONE, state IDLE after release.

Source files
------------

// File: rtl/sys_reg_file_pkg.sv
// sys_reg_file_pkg: shared register addresses, SR1 field layout, masks and FSM states.
package sys_reg_file_pkg;
  localparam logic [1:0] ADDR_SR1 = 2'd0;
  localparam logic [1:0] ADDR_PSR = 2'd1;
  localparam logic [1:0] ADDR_PPC = 2'd2;
  localparam int SR1_MMUMOD_LSB = 0;
  localparam int SR1_IM_BIT = 2;
  localparam int SR1_CMOD_LSB = 5;
  localparam logic [31:0] SR1_MASK = 32'h0000_0067;
  localparam logic [31:0] EXC_CLR_MASK = 32'h0000_0064;
  localparam logic [1:0] CMOD_KERNEL = 2'b00;
  typedef enum logic [1:0] {IDLE, EXC_SAVE, EXC_SET, RET} state_e;
endpackage

// File: rtl/sys_reg_file.sv
// sys_reg_file: SR1/PSR/PPC system registers with exception entry/return sequencing.
module sys_reg_file
  import sys_reg_file_pkg::*;
(
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iWR_VALID,
  output logic        oWR_BUSY,
  input  logic [1:0]  iWR_ADDR,
  input  logic [31:0] iWR_DATA,
  input  logic [1:0]  iRD_ADDR,
  output logic [31:0] oRD_DATA,
  input  logic        iEXC_VALID,
  input  logic [31:0] iEXC_PC,
  input  logic        iRET_VALID,
  output logic        oEXC_DONE,
  output logic        oRET_DONE,
  output logic [31:0] oSR1,
  output logic [1:0]  oSR1_MMUMOD,
  output logic        oSR1_IM,
  output logic [1:0]  oSR1_CMOD
);
  state_e state_q, state_d;
  logic [31:0] sr1_q, sr1_d, psr_q, psr_d, ppc_q, ppc_d;
  logic wr_go;
  function automatic logic [31:0] sr_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [31:0] wmask);
    return ((old_v & ~wmask) | (new_v & wmask)) & SR1_MASK;
  endfunction
  // Exception wins over return, return over write; losers are held off via busy.
  assign wr_go = (state_q == IDLE) && iWR_VALID && !iEXC_VALID && !iRET_VALID;
  always_comb begin
    state_d = state_q;
    sr1_d = sr1_q;
    psr_d = psr_q;
    ppc_d = ppc_q;
    case (state_q)
      IDLE: begin
        state_d = iEXC_VALID ? EXC_SAVE : iRET_VALID ? RET : IDLE;
        psr_d = iEXC_VALID ? sr1_q : (wr_go && iWR_ADDR == ADDR_PSR) ? sr_merge(psr_q, iWR_DATA, SR1_MASK) : psr_q;
        ppc_d = iEXC_VALID ? iEXC_PC : (wr_go && iWR_ADDR == ADDR_PPC) ? iWR_DATA : ppc_q;
        sr1_d = (!iEXC_VALID && iRET_VALID) ? psr_q : (wr_go && iWR_ADDR == ADDR_SR1) ? sr_merge(sr1_q, iWR_DATA, SR1_MASK) : sr1_q;
      end
      EXC_SAVE: begin
        state_d = EXC_SET;
        sr1_d = sr_merge(sr1_q, 32'(CMOD_KERNEL) << SR1_CMOD_LSB, EXC_CLR_MASK);
      end
      EXC_SET: state_d = IDLE;
      RET: state_d = IDLE;
    endcase
  end
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= IDLE;
      sr1_q <= '0;
      psr_q <= '0;
      ppc_q <= '0;
    end else begin
      state_q <= state_d;
      sr1_q <= sr1_d;
      psr_q <= psr_d;
      ppc_q <= ppc_d;
    end
  end
  always_comb begin
    oWR_BUSY = (state_q != IDLE) || iEXC_VALID || iRET_VALID;
    oEXC_DONE = state_q == EXC_SET;
    oRET_DONE = state_q == RET;
    oRD_DATA = (iRD_ADDR == ADDR_SR1) ? sr1_q : (iRD_ADDR == ADDR_PSR) ? psr_q : (iRD_ADDR == ADDR_PPC) ? ppc_q : '0;
    oSR1 = sr1_q;
    oSR1_MMUMOD = sr1_q[SR1_MMUMOD_LSB +: 2];
    oSR1_IM = sr1_q[SR1_IM_BIT];
    oSR1_CMOD = sr1_q[SR1_CMOD_LSB +: 2];
  end
endmodule

// File: tb/tb_sys_reg_file.sv
// tb_sys_reg_file: directed vector table plus hand-written exception/return/reset sequences.
module tb_sys_reg_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0, wr_busy;
  logic [1:0] wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0, rd_data, exc_pc = '0, sr1;
  logic exc_valid = 1'b0, ret_valid = 1'b0, exc_done, ret_done, sr1_im;
  logic [1:0] sr1_mmumod, sr1_cmod;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  sys_reg_file dut (
    .iCLOCK(clk), .inRESET(rst_n),
    .iWR_VALID(wr_valid), .oWR_BUSY(wr_busy), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
    .iRD_ADDR(rd_addr), .oRD_DATA(rd_data),
    .iEXC_VALID(exc_valid), .iEXC_PC(exc_pc), .iRET_VALID(ret_valid),
    .oEXC_DONE(exc_done), .oRET_DONE(ret_done),
    .oSR1(sr1), .oSR1_MMUMOD(sr1_mmumod), .oSR1_IM(sr1_im), .oSR1_CMOD(sr1_cmod)
  );
  typedef struct {
    logic wr;
    logic [1:0] wa;
    logic [31:0] wd;
    logic [1:0] ra;
    logic [31:0] exp_rd;
    logic [31:0] exp_sr1;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic rd(input logic [1:0] a, input string name, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask
  int exc_cyc, ret_cyc, wr_cyc, exc_pulses;
  logic wr_acc;
  initial begin
    vecs[0] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0, 32'h67};
    vecs[1] = '{1'b1, 2'd1, 32'h1234_5678, 2'd1, 32'h0, 32'h67};
    vecs[2] = '{1'b1, 2'd2, 32'hDEAD_BEEF, 2'd2, 32'h0, 32'h67};
    vecs[3] = '{1'b1, 2'd3, 32'hDEAD_BEEF, 2'd3, 32'h0, 32'h67};
    vecs[4] = '{1'b0, 2'd0, 32'h0, 2'd1, 32'h60, 32'h67};
    vecs[5] = '{1'b0, 2'd0, 32'h0, 2'd2, 32'hDEAD_BEEF, 32'h67};
    vecs[6] = '{1'b1, 2'd0, 32'h0000_0024, 2'd0, 32'h67, 32'h24};
    vecs[7] = '{1'b1, 2'd0, 32'h0000_0067, 2'd0, 32'h24, 32'h67};
    #12;
    chk("reset_sr1", sr1, 32'h0);
    chk("reset_busy", 32'(wr_busy), 32'h0);
    chk("reset_done", {30'h0, exc_done, ret_done}, 32'h0);
    rd(2'd1, "reset_psr", 32'h0);
    rd(2'd2, "reset_ppc", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_valid = vecs[i].wr;
      wr_addr = vecs[i].wa;
      wr_data = vecs[i].wd;
      rd_addr = vecs[i].ra;
      #1;
      chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp_rd);
      chk($sformatf("vec%0d_busy", i), 32'(wr_busy), 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_sr1", i), sr1, vecs[i].exp_sr1);
      wr_valid = 1'b0;
    end
    chk("field_mmumod", 32'(sr1_mmumod), 32'h3);
    chk("field_im", 32'(sr1_im), 32'h1);
    chk("field_cmod", 32'(sr1_cmod), 32'h3);
    // exception entry from SR1=0x67
    @(negedge clk);
    exc_valid = 1'b1;
    exc_pc = 32'h0000_1000;
    #1;
    chk("exc_c1_busy", 32'(wr_busy), 32'h1);
    chk("exc_c1_done", 32'(exc_done), 32'h0);
    @(posedge clk);
    #1;
    rd(2'd1, "exc_psr", 32'h67);
    rd(2'd2, "exc_ppc", 32'h1000);
    chk("exc_c2_sr1", sr1, 32'h67);
    chk("exc_c2_busy", 32'(wr_busy), 32'h1);
    chk("exc_c2_done", 32'(exc_done), 32'h0);
    @(posedge clk);
    #1;
    chk("exc_c3_sr1", sr1, 32'h03);
    chk("exc_c3_done", 32'(exc_done), 32'h1);
    chk("exc_c3_busy", 32'(wr_busy), 32'h1);
    exc_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("exc_after_done", 32'(exc_done), 32'h0);
    chk("exc_after_busy", 32'(wr_busy), 32'h0);
    ret_valid = 1'b1;
    #1;
    chk("ret_req_busy", 32'(wr_busy), 32'h1);
    @(posedge clk);
    #1;
    chk("ret_sr1", sr1, 32'h67);
    chk("ret_done", 32'(ret_done), 32'h1);
    ret_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ret_after_done", 32'(ret_done), 32'h0);
    // all three requests at once
    exc_valid = 1'b1;
    exc_pc = 32'h0000_2000;
    ret_valid = 1'b1;
    wr_valid = 1'b1;
    wr_addr = 2'd0;
    wr_data = 32'h0000_0004;
    exc_cyc = 0;
    ret_cyc = 0;
    wr_cyc = 0;
    exc_pulses = 0;
    for (int k = 1; k <= 20 && wr_cyc == 0; k++) begin
      @(negedge clk);
      wr_acc = wr_valid && !wr_busy;
      @(posedge clk);
      #1;
      if (wr_acc) begin
        wr_cyc = k;
        wr_valid = 1'b0;
      end
      if (exc_done) begin
        exc_cyc = k;
        exc_pulses++;
        exc_valid = 1'b0;
      end
      if (ret_done) begin
        ret_cyc = k;
        chk("prio_ret_sr1", sr1, 32'h67);
        ret_valid = 1'b0;
      end
    end
    chk("prio_exc_cyc", 32'(exc_cyc), 32'd2);
    chk("prio_ret_cyc", 32'(ret_cyc), 32'd4);
    chk("prio_wr_cyc", 32'(wr_cyc), 32'd6);
    chk("prio_exc_pulses", 32'(exc_pulses), 32'd1);
    chk("prio_final_sr1", sr1, 32'h04);
    // reset while in EXC_SET
    exc_valid = 1'b1;
    exc_pc = 32'h0000_3000;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exc_valid = 1'b0;
    #1;
    chk("rst_mid_done", 32'(exc_done), 32'h0);
    chk("rst_mid_sr1", sr1, 32'h0);
    rd(2'd1, "rst_mid_psr", 32'h0);
    rd(2'd2, "rst_mid_ppc", 32'h0);
    @(negedge clk);
    chk("rst_mid_done_neg", 32'(exc_done), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel_busy", 32'(wr_busy), 32'h0);
    chk("rst_rel_done", 32'(exc_done), 32'h0);
    wr_valid = 1'b1;
    wr_addr = 2'd0;
    wr_data = 32'h0000_0004;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    chk("rst_rel_write", sr1, 32'h04);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
